// File: rtl/wb_stage.sv
// Write-back stage: selects register-file write data, owns HI/LO with EX bypass,
// drives the debug trace and counts retired instructions.
module wb_stage #(
   parameter logic [7:0] OP_JAL    = 8'h20,
   parameter logic [7:0] OP_JALR   = 8'h21,
   parameter logic [7:0] OP_MFHI   = 8'h36,
   parameter logic [7:0] OP_MFLO   = 8'h37,
   parameter logic [7:0] OP_MTHI   = 8'h30,
   parameter logic [7:0] OP_MTLO   = 8'h31,
   parameter logic [7:0] OP_MULDIV = 8'h32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in_fourPC,
   input  logic [31:0] in_memResult,
   input  logic [4:0]  in_writeDataReg,
   input  logic [7:0]  in_inst_name,
   input  logic [31:0] in_HI_data,
   input  logic [31:0] in_LO_data,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [31:0] hi_fwd,
   output logic [31:0] lo_fwd,
   output logic [31:0] debug_wb_pc,
   output logic [3:0]  debug_wb_rf_wen,
   output logic [4:0]  debug_wb_rf_wnum,
   output logic [31:0] debug_wb_rf_wdata,
   output logic [31:0] retire_cnt
);

   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] retire_cnt_q, retire_cnt_d;

   logic retire;
   logic is_mthi, is_mtlo, is_muldiv, is_link;

   always_comb begin
      retire    = in_valid & ~rst;
      is_mthi   = (in_inst_name == OP_MTHI);
      is_mtlo   = (in_inst_name == OP_MTLO);
      is_muldiv = (in_inst_name == OP_MULDIV);
      is_link   = (in_inst_name == OP_JAL) || (in_inst_name == OP_JALR);

      hi_d = hi_q;
      lo_d = lo_q;
      if (retire) begin
         if (is_mthi)   hi_d = in_memResult;
         if (is_mtlo)   lo_d = in_memResult;
         if (is_muldiv) begin
            hi_d = in_HI_data;
            lo_d = in_LO_data;
         end
      end
      retire_cnt_d = retire ? retire_cnt_q + 32'd1 : retire_cnt_q;

      // MFHI/MFLO read the architectural registers; any older writer has already left WB.
      rf_we    = retire && (in_writeDataReg != 5'd0) && !is_mthi && !is_mtlo && !is_muldiv;
      rf_waddr = in_writeDataReg;
      if (is_link)
         rf_wdata = in_fourPC + 32'd4;
      else if (in_inst_name == OP_MFHI)
         rf_wdata = hi_q;
      else if (in_inst_name == OP_MFLO)
         rf_wdata = lo_q;
      else
         rf_wdata = in_memResult;

      hi_fwd = hi_d;
      lo_fwd = lo_d;

      debug_wb_pc       = in_fourPC - 32'd4;
      debug_wb_rf_wen   = {4{rf_we}};
      debug_wb_rf_wnum  = rf_waddr;
      debug_wb_rf_wdata = rf_wdata;
      retire_cnt        = retire_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q         <= 32'h0;
         lo_q         <= 32'h0;
         retire_cnt_q <= 32'h0;
      end else begin
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

endmodule
